// File: rtl/timer_regs.sv
// timer_regs: register bank and 64-bit counting engine of the timer IP.
// Sits behind the APB slave decode; consumes wr_en/rd_en strobes, holds
// control/counter/compare/interrupt state, returns prdata and drives tim_int.
module timer_regs #(
  parameter int          ADDR_W  = 12,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              tim_int
);

  // Word offsets (byte address >> 2)
  localparam logic [ADDR_W-3:0] OFS_TCR   = (ADDR_W-2)'(3'd0);
  localparam logic [ADDR_W-3:0] OFS_TDR0  = (ADDR_W-2)'(3'd1);
  localparam logic [ADDR_W-3:0] OFS_TDR1  = (ADDR_W-2)'(3'd2);
  localparam logic [ADDR_W-3:0] OFS_TCMP0 = (ADDR_W-2)'(3'd3);
  localparam logic [ADDR_W-3:0] OFS_TCMP1 = (ADDR_W-2)'(3'd4);
  localparam logic [ADDR_W-3:0] OFS_TIER  = (ADDR_W-2)'(3'd5);
  localparam logic [ADDR_W-3:0] OFS_TISR  = (ADDR_W-2)'(3'd6);

  logic        timer_en_q, timer_en_d;
  logic        div_en_q,   div_en_d;
  logic [3:0]  div_val_q,  div_val_d;
  logic [3:0]  div_cnt_q,  div_cnt_d;
  logic [63:0] cnt_q,      cnt_d;
  logic [63:0] cmp_q,      cmp_d;
  logic        int_en_q,   int_en_d;
  logic        int_st_q,   int_st_d;

  logic [ADDR_W-3:0] word_s;
  logic wr_tcr_s, wr_tdr0_s, wr_tdr1_s, wr_tcmp0_s, wr_tcmp1_s, wr_tier_s, wr_tisr_s;
  logic tick_s, match_s;
  logic unused_lsb_s;

  // Byte-lane bits are ignored; only whole words are addressed.
  assign word_s       = paddr[ADDR_W-1:2];
  assign unused_lsb_s = ^paddr[1:0];

  assign wr_tcr_s   = wr_en & (word_s == OFS_TCR);
  assign wr_tdr0_s  = wr_en & (word_s == OFS_TDR0);
  assign wr_tdr1_s  = wr_en & (word_s == OFS_TDR1);
  assign wr_tcmp0_s = wr_en & (word_s == OFS_TCMP0);
  assign wr_tcmp1_s = wr_en & (word_s == OFS_TCMP1);
  assign wr_tier_s  = wr_en & (word_s == OFS_TIER);
  assign wr_tisr_s  = wr_en & (word_s == OFS_TISR);

  // A count step happens every cycle, or only when the prescaler reaches div_val.
  assign tick_s  = timer_en_q & (~div_en_q | (div_cnt_q == div_val_q));
  assign match_s = (cnt_q == cmp_q);

  // Next-state logic for control, prescaler, counter, compare and interrupt state.
  always_comb begin
    timer_en_d = timer_en_q;
    div_en_d   = div_en_q;
    div_val_d  = div_val_q;
    div_cnt_d  = div_cnt_q;
    cnt_d      = cnt_q;
    cmp_d      = cmp_q;
    int_en_d   = int_en_q;
    int_st_d   = int_st_q;

    if (wr_tcr_s) begin
      timer_en_d = pwdata[0];
      div_en_d   = pwdata[1];
      div_val_d  = pwdata[11:8];
    end else begin
      timer_en_d = timer_en_q;
    end

    // Prescaler restarts whenever it is idle or its configuration is rewritten.
    if (~timer_en_q | ~div_en_q | wr_tcr_s) begin
      div_cnt_d = 4'd0;
    end else if (div_cnt_q == div_val_q) begin
      div_cnt_d = 4'd0;
    end else begin
      div_cnt_d = div_cnt_q + 4'd1;
    end

    // A software load of either half suppresses the count step for that cycle.
    if (wr_tdr0_s) begin
      cnt_d = {cnt_q[63:32], pwdata};
    end else if (wr_tdr1_s) begin
      cnt_d = {pwdata, cnt_q[31:0]};
    end else if (tick_s) begin
      cnt_d = cnt_q + 64'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (wr_tcmp0_s) begin
      cmp_d = {cmp_q[63:32], pwdata};
    end else if (wr_tcmp1_s) begin
      cmp_d = {pwdata, cmp_q[31:0]};
    end else begin
      cmp_d = cmp_q;
    end

    if (wr_tier_s) begin
      int_en_d = pwdata[0];
    end else begin
      int_en_d = int_en_q;
    end

    // Sticky status: a match beats a simultaneous write-1-to-clear.
    if (match_s) begin
      int_st_d = 1'b1;
    end else if (wr_tisr_s & pwdata[0]) begin
      int_st_d = 1'b0;
    end else begin
      int_st_d = int_st_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_en_q <= 1'b0;
      div_en_q   <= 1'b0;
      div_val_q  <= 4'd0;
      div_cnt_q  <= 4'd0;
      cnt_q      <= 64'd0;
      cmp_q      <= CMP_RST;
      int_en_q   <= 1'b0;
      int_st_q   <= 1'b0;
    end else begin
      timer_en_q <= timer_en_d;
      div_en_q   <= div_en_d;
      div_val_q  <= div_val_d;
      div_cnt_q  <= div_cnt_d;
      cnt_q      <= cnt_d;
      cmp_q      <= cmp_d;
      int_en_q   <= int_en_d;
      int_st_q   <= int_st_d;
    end
  end

  // Read mux: returns the addressed register during a read strobe, else zero.
  always_comb begin
    prdata = 32'd0;
    if (rd_en) begin
      case (word_s)
        OFS_TCR:   prdata = {20'd0, div_val_q, 6'd0, div_en_q, timer_en_q};
        OFS_TDR0:  prdata = cnt_q[31:0];
        OFS_TDR1:  prdata = cnt_q[63:32];
        OFS_TCMP0: prdata = cmp_q[31:0];
        OFS_TCMP1: prdata = cmp_q[63:32];
        OFS_TIER:  prdata = {31'd0, int_en_q};
        OFS_TISR:  prdata = {31'd0, int_st_q};
        default:   prdata = 32'd0;
      endcase
    end else begin
      prdata = 32'd0;
    end
  end

  assign tim_int = int_st_q & int_en_q;

endmodule
